fifo_wr_arbiter: RTL



---
 rtl/fifo_wr_arbiter.sv | 87 ++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among REQ_NUM producers.
// A grant lasts until the owner's last word or MAX_BURST words, whichever comes first.
module fifo_wr_arbiter #(
   parameter int DWIDTH    = 4,
   parameter int REQ_NUM   = 4,
   parameter int MAX_BURST = 16
) (
   input  logic                      clk_i,
   input  logic                      srst_i,
   input  logic [REQ_NUM-1:0]        req_valid_i,
   input  logic [REQ_NUM*DWIDTH-1:0] req_data_i,
   input  logic [REQ_NUM-1:0]        req_last_i,
   output logic [REQ_NUM-1:0]        req_ready_o,
   input  logic                      fifo_full_i,
   output logic                      fifo_wrreq_o,
   output logic [DWIDTH-1:0]         fifo_data_o,
   output logic [REQ_NUM-1:0]        grant_o,
   output logic                      split_o
);
   localparam int PW = $clog2(REQ_NUM);
   typedef enum logic {IDLE, BURST} state_e;
   state_e             state_q, state_d;
   logic [REQ_NUM-1:0] grant_q, grant_d;
   logic [PW-1:0]      ptr_q, ptr_d, own, win;
   logic [7:0]         beat_q, beat_d;
   logic [PW:0]        scan;
   logic               found, xfer, limit, eob;
   always_comb begin
      own = '0;
      for (int i = 0; i < REQ_NUM; i++) if (grant_q[i]) own = PW'(i);
   end
   // circular scan starting at ptr; ptr+i never reaches 2*REQ_NUM, so one subtraction wraps it
   always_comb begin
      found = 1'b0;
      win   = '0;
      scan  = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         scan = {1'b0, ptr_q} + (PW+1)'(i);
         scan = scan >= (PW+1)'(REQ_NUM) ? scan - (PW+1)'(REQ_NUM) : scan;
         if (!found && req_valid_i[scan[PW-1:0]]) begin
            found = 1'b1;
            win   = scan[PW-1:0];
         end
      end
   end
   always_comb begin
      fifo_data_o = '0;
      for (int i = 0; i < REQ_NUM; i++) fifo_data_o |= req_data_i[i*DWIDTH +: DWIDTH] & {DWIDTH{grant_q[i]}};
   end
   assign xfer         = state_q == BURST && req_valid_i[own] && !fifo_full_i;
   assign limit        = beat_q == 8'(MAX_BURST-1);
   assign eob          = xfer && (req_last_i[own] || limit);
   assign split_o      = xfer && !req_last_i[own] && limit;
   assign fifo_wrreq_o = xfer;
   assign req_ready_o  = state_q == BURST && !fifo_full_i ? grant_q : '0;
   assign grant_o      = grant_q;
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      beat_d  = beat_q;
      if (state_q == IDLE && found) begin
         state_d = BURST;
         grant_d = REQ_NUM'(1) << win;
         beat_d  = '0;
      end
      if (xfer) beat_d = beat_q + 8'd1;
      if (eob) begin
         state_d = IDLE;
         grant_d = '0;
         ptr_d   = own == PW'(REQ_NUM-1) ? '0 : own + PW'(1);
      end
   end
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         beat_q  <= beat_d;
      end
   end
endmodule
